seven_seg_scan: RTL



---
 rtl/seven_seg_scan_if.sv | 14 +
 rtl/seven_seg_scan.sv | 89 ++++++++
 2 files changed

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: value/segment bundle between the datapath (master) and the scan driver (slave)
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] number;
  logic [NUM_DIGITS-1:0]   dots;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [7:0]              hex;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_start;
  modport master (output load, number, dots, digit_en, input hex, anode, frame_start);
  modport slave  (input load, number, dots, digit_en, output hex, anode, frame_start);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed N-digit common-anode 7-seg driver with blanking and frame-aligned double buffer
// Optional leading-zero blanking: define SEVEN_SEG_LZB_EN.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    run, wrap, frame, pending, show;
  logic [4*NUM_DIGITS-1:0] sh_num, d_num;
  logic [NUM_DIGITS-1:0]   sh_dot, sh_en, d_dot, d_en, sup;
  logic [3:0]              nib;
  // run=0 makes the first edge after reset act as the wrap into digit 0's slot
  assign wrap  = !run || cnt == CW'(SCAN_DIV - 1);
  assign frame = wrap && idx == IW'(NUM_DIGITS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      idx <= IW'(NUM_DIGITS - 1);
    end else begin
      run <= 1'b1;
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= frame ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_num  <= '0;
      sh_dot  <= '0;
      sh_en   <= '0;
      d_num   <= '0;
      d_dot   <= '0;
      d_en    <= '0;
      pending <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_num <= bus.number;
        sh_dot <= bus.dots;
        sh_en  <= bus.digit_en;
      end
      if (frame && bus.load) begin
        d_num <= bus.number;
        d_dot <= bus.dots;
        d_en  <= bus.digit_en;
      end else if (frame && pending) begin
        d_num <= sh_num;
        d_dot <= sh_dot;
        d_en  <= sh_en;
      end
      pending <= frame ? 1'b0 : (bus.load | pending);
    end
  end
`ifdef SEVEN_SEG_LZB_EN
  logic lead;
  always_comb begin
    lead = 1'b1;
    sup  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead   = lead && d_num[4*i +: 4] == 4'h0 && !d_dot[i];
      sup[i] = lead;
    end
  end
`else
  assign sup = '0;
`endif
  assign nib  = d_num[4*idx +: 4];
  assign show = run && cnt >= CW'(BLANK_CYCLES) && d_en[idx] && !sup[idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hex         <= 8'hFF;
      bus.anode       <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hex         <= show ? {~d_dot[idx], GLYPH[nib]} : 8'hFF;
      bus.anode       <= show ? ~(NUM_DIGITS'(1) << idx) : '1;
      bus.frame_start <= run && cnt == '0 && idx == '0;
    end
  end
endmodule
